// File: rtl/hps_load_dispatch.sv
// hps_load_dispatch: splits the hps_io download stream into ROM writes, variant byte and DIP bank; stretches core reset.
// Latency: ROM write one cycle after ioctl_wr. Optional HPS_LOAD_CHECKSUM_EN adds rom_sum.
// Backpressure: none, every strobe is consumed or dropped in the cycle it arrives.
module hps_load_dispatch #(
  parameter int ROM_AW    = 17,
  parameter int NUM_DIP   = 8,
  parameter int ROM_INDEX = 0,
  parameter int MOD_INDEX = 1,
  parameter int DIP_INDEX = 254,
  parameter int RST_HOLD  = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  input  logic [7:0]           ioctl_index,
  input  logic                 reset_req,
  output logic [ROM_AW-1:0]    rom_addr,
  output logic [7:0]           rom_data,
  output logic                 rom_wr,
  output logic [7:0]           mod_id,
  output logic [NUM_DIP*8-1:0] dip_flat,
  output logic                 dip_valid,
  output logic                 rom_overflow,
  output logic                 load_busy,
  output logic                 core_reset
`ifdef HPS_LOAD_CHECKSUM_EN
  ,
  output logic [15:0]          rom_sum
`endif
);

  localparam int            CW        = $clog2(RST_HOLD + 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(RST_HOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_ROM,
    S_LOAD_MOD,
    S_LOAD_DIP,
    S_LOAD_OTHER,
    S_HOLD
  } state_t;

  state_t               state_q, state_d, start_state, act;
  logic                 dl_q, dl_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ROM_AW-1:0]    rom_addr_q, rom_addr_d;
  logic [7:0]           rom_data_q, rom_data_d;
  logic                 rom_wr_q, rom_wr_d;
  logic [7:0]           mod_id_q, mod_id_d;
  logic [NUM_DIP*8-1:0] dip_q, dip_d;
  logic                 dip_valid_q, dip_valid_d;
  logic                 ovf_q, ovf_d;
  logic                 load_busy_q, load_busy_d;
  logic                 dl_rise, start, wr_en, rom_hit, in_range, rom_entry;
`ifdef HPS_LOAD_CHECKSUM_EN
  logic [15:0]          sum_q, sum_d;
`endif

  always_comb begin
    dl_rise = ioctl_download & ~dl_q;
    start   = dl_rise & ((state_q == S_IDLE) | (state_q == S_HOLD));
    if (ioctl_index == 8'(ROM_INDEX))      start_state = S_LOAD_ROM;
    else if (ioctl_index == 8'(MOD_INDEX)) start_state = S_LOAD_MOD;
    else if (ioctl_index == 8'(DIP_INDEX)) start_state = S_LOAD_DIP;
    else                                   start_state = S_LOAD_OTHER;
    rom_entry = start & (start_state == S_LOAD_ROM);

    // A strobe on the rising-edge cycle belongs to the load being opened.
    act      = start ? start_state : state_q;
    wr_en    = ioctl_wr & ioctl_download;
    rom_hit  = wr_en & (act == S_LOAD_ROM);
    in_range = (ioctl_addr >> ROM_AW) == 25'd0;
    dl_d     = ioctl_download;

    // Reload while a ROM download is open so release lands RST_HOLD cycles after it closes.
    if (reset_req | ((act == S_LOAD_ROM) & ioctl_download)) cnt_d = HOLD_INIT;
    else if (cnt_q != '0)                                   cnt_d = cnt_q - CW'(1);
    else                                                    cnt_d = cnt_q;

    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = start_state;
      end
      S_HOLD: begin
        if (start)              state_d = start_state;
        else if (cnt_d == '0)   state_d = S_IDLE;
      end
      S_LOAD_ROM: begin
        if (!ioctl_download) state_d = (cnt_d != '0) ? S_HOLD : S_IDLE;
      end
      default: begin
        if (!ioctl_download) state_d = S_IDLE;
      end
    endcase

    load_busy_d = (state_d == S_LOAD_ROM) | (state_d == S_LOAD_MOD) |
                  (state_d == S_LOAD_DIP) | (state_d == S_LOAD_OTHER);

    rom_wr_d   = rom_hit & in_range;
    rom_addr_d = rom_wr_d ? ioctl_addr[ROM_AW-1:0] : rom_addr_q;
    rom_data_d = rom_wr_d ? ioctl_dout : rom_data_q;
    ovf_d      = (rom_hit & ~in_range) | (ovf_q & ~rom_entry);

    mod_id_d = (wr_en & (act == S_LOAD_MOD)) ? ioctl_dout : mod_id_q;

    dip_d = dip_q;
    for (int k = 0; k < NUM_DIP; k++) begin
      if (wr_en && (act == S_LOAD_DIP) && (ioctl_addr == 25'(k))) dip_d[8*k +: 8] = ioctl_dout;
    end
    dip_valid_d = dip_valid_q | ((state_q == S_LOAD_DIP) & ~ioctl_download);

`ifdef HPS_LOAD_CHECKSUM_EN
    sum_d = rom_entry ? 16'd0 : sum_q;
    if (rom_wr_d) sum_d = sum_d + {8'd0, ioctl_dout};
`endif
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b0;
      cnt_q       <= HOLD_INIT;
      rom_addr_q  <= '0;
      rom_data_q  <= '0;
      rom_wr_q    <= 1'b0;
      mod_id_q    <= '0;
      dip_q       <= '0;
      dip_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      load_busy_q <= 1'b0;
`ifdef HPS_LOAD_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      rom_data_q  <= rom_data_d;
      rom_wr_q    <= rom_wr_d;
      mod_id_q    <= mod_id_d;
      dip_q       <= dip_d;
      dip_valid_q <= dip_valid_d;
      ovf_q       <= ovf_d;
      load_busy_q <= load_busy_d;
`ifdef HPS_LOAD_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign rom_addr     = rom_addr_q;
  assign rom_data     = rom_data_q;
  assign rom_wr       = rom_wr_q;
  assign mod_id       = mod_id_q;
  assign dip_flat     = dip_q;
  assign dip_valid    = dip_valid_q;
  assign rom_overflow = ovf_q;
  assign load_busy    = load_busy_q;
  assign core_reset   = reset_req | (state_q == S_LOAD_ROM) | (state_q == S_HOLD) | (cnt_q != '0);
`ifdef HPS_LOAD_CHECKSUM_EN
  assign rom_sum      = sum_q;
`endif

endmodule

// File: tb/tb_hps_load_dispatch.sv
// Bench for hps_load_dispatch: transaction-level model of the download stream and a reset-source timeline.
module tb_hps_load_dispatch;

  localparam int ROM_AW   = 17;
  localparam int NUM_DIP  = 8;
  localparam int RST_HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        reset_req = 1'b0;
  logic [ROM_AW-1:0]    rom_addr;
  logic [7:0]           rom_data;
  logic                 rom_wr;
  logic [7:0]           mod_id;
  logic [NUM_DIP*8-1:0] dip_flat;
  logic                 dip_valid;
  logic                 rom_overflow;
  logic                 load_busy;
  logic                 core_reset;
`ifdef HPS_LOAD_CHECKSUM_EN
  logic [15:0]          rom_sum;
  logic [15:0]          m_sum = '0;
`endif

  hps_load_dispatch #(
    .ROM_AW(ROM_AW), .NUM_DIP(NUM_DIP), .ROM_INDEX(0), .MOD_INDEX(1),
    .DIP_INDEX(254), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .reset_req(reset_req),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_wr(rom_wr), .mod_id(mod_id),
    .dip_flat(dip_flat), .dip_valid(dip_valid), .rom_overflow(rom_overflow),
    .load_busy(load_busy), .core_reset(core_reset)
`ifdef HPS_LOAD_CHECKSUM_EN
    , .rom_sum(rom_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          cyc;
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_src = -1000;
  bit   m_rom_dl = 1'b0;
  logic [7:0]  m_mod = '0;
  logic [63:0] m_dip = '0;
  bit   m_dip_valid = 1'b0;
  bit   m_ovf = 1'b0;
  wr_t  exp_q[$];
  int   q_addr[$];
  int   q_data[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Timeline of reset sources: async reset, reset_req, or an open ROM download.
  always @(posedge clk_sys) begin
    if (reset || reset_req || (ioctl_download && m_rom_dl)) last_src = cyc;
    cyc++;
  end

  always @(negedge clk_sys) begin : mon
    bit exp_now;
    bit exp_cr;
    exp_cr = reset || reset_req || ((cyc - last_src) <= RST_HOLD);
    chk("core_reset", core_reset, exp_cr);
    exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    if (rom_wr || exp_now) begin
      chk("rom_wr", rom_wr, exp_now);
      if (exp_now) begin
        chk("rom_addr", rom_addr, exp_q[0].a);
        chk("rom_data", rom_data, exp_q[0].d);
        void'(exp_q.pop_front());
      end
    end
  end

  function automatic int kind_of(input logic [7:0] idx);
    if (idx == 8'd0) return 0;
    if (idx == 8'd1) return 1;
    if (idx == 8'd254) return 2;
    return 3;
  endfunction

  task automatic drive_wr(input int kind, input int a, input int d);
    wr_t w;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = 8'(d);
    case (kind)
      0: begin
        if (a < (1 << ROM_AW)) begin
          w.cyc = cyc + 1; w.a = 17'(a); w.d = 8'(d);
          exp_q.push_back(w);
`ifdef HPS_LOAD_CHECKSUM_EN
          m_sum = m_sum + 16'(d);
`endif
        end else begin
          m_ovf = 1'b1;
        end
      end
      1: m_mod = 8'(d);
      2: if (a < NUM_DIP) m_dip[a*8 +: 8] = 8'(d);
      default: ;
    endcase
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic check_state(input string pfx);
    chk({pfx, "_load_busy"}, load_busy, 1'b0);
    chk({pfx, "_mod_id"}, mod_id, m_mod);
    chk({pfx, "_dip_flat"}, dip_flat, m_dip);
    chk({pfx, "_dip_valid"}, dip_valid, m_dip_valid);
    chk({pfx, "_rom_overflow"}, rom_overflow, m_ovf);
`ifdef HPS_LOAD_CHECKSUM_EN
    chk({pfx, "_rom_sum"}, rom_sum, m_sum);
`endif
  endtask

  // First strobe shares the rising-edge cycle of ioctl_download.
  task automatic do_load(input logic [7:0] idx, input int chg_idx);
    int kind;
    kind = kind_of(idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    m_rom_dl       = (kind == 0);
    if (kind == 0) begin
      m_ovf = 1'b0;
`ifdef HPS_LOAD_CHECKSUM_EN
      m_sum = '0;
`endif
    end
    for (int i = 0; i < q_addr.size(); i++) begin
      if (i > 0) repeat ($urandom_range(0, 2)) tick();
      drive_wr(kind, q_addr[i], q_data[i]);
      if (i == 0) begin
        chk("load_busy_on", load_busy, 1'b1);
        if (chg_idx >= 0) ioctl_index = 8'(chg_idx);
      end
    end
    ioctl_download = 1'b0;
    tick();
    if (kind == 2) m_dip_valid = 1'b1;
    check_state("post");
  endtask

  task automatic pulse_req(input int n);
    reset_req = 1'b1;
    repeat (n) tick();
    reset_req = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_rom_wr", rom_wr, 1'b0);
    chk("rst_core_reset", core_reset, 1'b1);
    check_state("rst");
    reset = 1'b0;
    repeat (20) tick();
    chk("idle_load_busy", load_busy, 1'b0);

    q_addr = '{0, 1, 2, 3};
    q_data = '{'hA5, 'h5A, 'hFF, 'h00};
    do_load(8'd0, -1);
`ifdef HPS_LOAD_CHECKSUM_EN
    chk("rom_sum_const", rom_sum, 16'h01FE);
`endif
    repeat (20) tick();

    q_addr = '{'h20000, 'h1FFFF};
    q_data = '{'h33, 'h44};
    do_load(8'd0, -1);
    chk("ovf_set", rom_overflow, 1'b1);
    repeat (3) tick();
    q_addr = '{5};
    q_data = '{'h66};
    do_load(8'd0, -1);
    chk("ovf_cleared", rom_overflow, 1'b0);
    repeat (20) tick();

    q_addr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    q_data = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
    do_load(8'd254, -1);
    chk("dip_const", dip_flat, 64'h11100F0E0D0C0B0A);
    chk("dip_valid_const", dip_valid, 1'b1);

    q_addr = '{0, 1};
    q_data = '{0, 1};
    do_load(8'd1, 0);
    chk("mod_const", mod_id, 8'd1);
    repeat (4) tick();

    pulse_req(3);
    repeat (25) tick();
    q_addr = '{7, 8};
    q_data = '{'h12, 'h34};
    do_load(8'd0, -1);
    repeat (6) tick();
    q_addr = '{9};
    q_data = '{'h56};
    do_load(8'd0, -1);
    repeat (25) tick();

    for (int it = 0; it < 40; it++) begin
      int t;
      int n;
      logic [7:0] idx;
      t = $urandom_range(0, 3);
      idx = (t == 0) ? 8'd0 : (t == 1) ? 8'd1 : (t == 2) ? 8'd254 : 8'd7;
      n = $urandom_range(1, 8);
      q_addr.delete();
      q_data.delete();
      for (int k = 0; k < n; k++) begin
        int a;
        if (t == 0) a = ($urandom_range(0, 7) == 0) ? int'(32'h20000 + $urandom_range(0, 255))
                                                   : int'($urandom_range(0, 32'h1FFFF));
        else if (t == 2) a = $urandom_range(0, 11);
        else a = $urandom_range(0, 15);
        q_addr.push_back(a);
        q_data.push_back($urandom_range(0, 255));
      end
      do_load(idx, -1);
      if ($urandom_range(0, 2) == 0) pulse_req($urandom_range(1, 4));
      repeat ($urandom_range(1, 20)) tick();
    end
    repeat (20) tick();

    // Async reset while a ROM write strobe is on the output.
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    m_rom_dl       = 1'b1;
    m_ovf          = 1'b0;
    drive_wr(0, 3, 'h11);
    reset          = 1'b1;
    ioctl_download = 1'b0;
    exp_q.delete();
    m_mod = '0; m_dip = '0; m_dip_valid = 1'b0; m_ovf = 1'b0; m_rom_dl = 1'b0;
`ifdef HPS_LOAD_CHECKSUM_EN
    m_sum = '0;
`endif
    #1;
    chk("arst_rom_wr", rom_wr, 1'b0);
    chk("arst_core_reset", core_reset, 1'b1);
    check_state("arst");
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("arst_idle", load_busy, 1'b0);
    q_addr = '{0};
    q_data = '{'h5C};
    do_load(8'd1, -1);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
